// File: rtl/i2s_pkg.sv
// i2s_pkg: shared state encoding, channel constants and default parameters for the I2S frame scheduler.
package i2s_pkg;
    typedef enum logic [1:0] {IDLE, SYNC, DATA, PAD} state_t;
    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;
    localparam int DEF_SAMPLE_BITS = 8;
    localparam int DEF_SLOT_BITS   = 16;
    localparam int DEF_CLK_DIV     = 2;
    localparam int DEF_DEPTH       = 10;
endpackage

// File: rtl/i2s_frame_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter with registered one-hot grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [1:0] gnt_next
);
    logic prio;
    // prio=1 means consumer 1 wins a tie because consumer 0 was granted last
    always_comb gnt_next = !en ? 2'b00 : (req == 2'b11) ? (prio ? 2'b10 : 2'b01) : req;
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt  <= 2'b00;
            prio <= 1'b0;
        end else begin
            gnt  <= gnt_next;
            prio <= gnt_next[0] ? 1'b1 : gnt_next[1] ? 1'b0 : prio;
        end
    end
endmodule

// File: rtl/i2s_frame_scheduler.sv
// i2s_frame_scheduler: master I2S timing generator, per-frame buffer write and round-robin read sequencing.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing (no one-bit delay, SYNC unused).
module i2s_frame_scheduler
    import i2s_pkg::*;
#(
    parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
    parameter int SLOT_BITS   = DEF_SLOT_BITS,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int DEPTH       = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          sck_o,
    output logic          ws_o,
    output logic          shift_en_o,
    output logic          shift_ch_o,
    output logic          word_done_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    input  logic [1:0]    rd_req_i,
    output logic [1:0]    rd_gnt_o,
    output logic [AW-1:0] rd_addr_o,
    output logic [CW-1:0] count_o,
    output logic          overflow_o
);
`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam int     FIRST_BIT  = 0;
    localparam state_t SLOT_START = DATA;
`else
    localparam int     FIRST_BIT  = 1;
    localparam state_t SLOT_START = SYNC;
`endif
    localparam int LAST_BIT = FIRST_BIT + SAMPLE_BITS - 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(SLOT_BITS);

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [1:0]    gnt_next;
    logic          tick, rise, fall, slot_end, word_end, wr_fire, pop, full, drop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign tick     = (state != IDLE) && (div_cnt == DW'(CLK_DIV - 1));
    assign rise     = tick && !sck_o;
    assign fall     = tick && sck_o;
    assign slot_end = fall && (bit_cnt == BW'(SLOT_BITS - 1));
    // bit_cnt only moves on a fall, so it still names the shifted bit one clk later
    assign word_end = shift_en_o && (bit_cnt == BW'(LAST_BIT));
    assign wr_fire  = word_end && (ws_o == RIGHT);
    assign pop      = |gnt_next;
    assign full     = count_o == CW'(DEPTH);
    assign drop     = wr_fire && full && !pop;
    assign shift_ch_o = ws_o;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = enable ? SLOT_START : IDLE;
            SYNC:    state_nxt = fall ? DATA : SYNC;
            DATA:    state_nxt = (fall && bit_cnt == BW'(LAST_BIT)) ? PAD : DATA;
            default: state_nxt = state;
        endcase
        // enable is only honoured at the end of a right slot
        if (slot_end)
            state_nxt = (ws_o == RIGHT && !enable) ? IDLE : SLOT_START;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            sck_o       <= 1'b0;
            ws_o        <= LEFT;
            shift_en_o  <= 1'b0;
            word_done_o <= 1'b0;
            wr_en_o     <= 1'b0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= (state == IDLE || tick) ? '0 : div_cnt + DW'(1);
            sck_o       <= tick ? ~sck_o : sck_o;
            bit_cnt     <= slot_end ? '0 : fall ? bit_cnt + BW'(1) : bit_cnt;
            ws_o        <= slot_end ? ~ws_o : ws_o;
            shift_en_o  <= rise && (state == DATA);
            word_done_o <= word_end;
            wr_en_o     <= wr_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_addr_o  <= '0;
            rd_addr_o  <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            wr_ptr     <= wr_fire ? inc(wr_ptr) : wr_ptr;
            wr_addr_o  <= wr_fire ? wr_ptr : wr_addr_o;
            rd_ptr     <= (pop || drop) ? inc(rd_ptr) : rd_ptr;
            rd_addr_o  <= pop ? rd_ptr : rd_addr_o;
            count_o    <= (wr_fire && !pop && !full) ? count_o + CW'(1) :
                          (pop && !wr_fire) ? count_o - CW'(1) : count_o;
            overflow_o <= overflow_o | drop;
        end
    end

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .en       (count_o != '0),
        .req      (rd_req_i),
        .gnt      (rd_gnt_o),
        .gnt_next (gnt_next)
    );
endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// tb_i2s_frame_scheduler: randomized bench checking every output each clk against a frame-level reference model.
module tb_i2s_frame_scheduler;
    localparam int SB = 8, SL = 16, CD = 2, DEPTH = 10;
    localparam int AW = $clog2(DEPTH), CW = $clog2(DEPTH + 1);
    localparam int F = 4 * CD * SL;
`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam int FIRST = 0;
`else
    localparam int FIRST = 1;
`endif
    localparam int LAST = FIRST + SB - 1;

    logic          clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [1:0]    rd_req_i = 2'b00;
    logic          sck_o, ws_o, shift_en_o, shift_ch_o, word_done_o, wr_en_o, overflow_o;
    logic [AW-1:0] wr_addr_o, rd_addr_o;
    logic [1:0]    rd_gnt_o;
    logic [CW-1:0] count_o;

    always #5 clk = ~clk;

    i2s_frame_scheduler #(.SAMPLE_BITS(SB), .SLOT_BITS(SL), .CLK_DIV(CD), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sck_o(sck_o), .ws_o(ws_o),
        .shift_en_o(shift_en_o), .shift_ch_o(shift_ch_o), .word_done_o(word_done_o),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .rd_req_i(rd_req_i), .rd_gnt_o(rd_gnt_o),
        .rd_addr_o(rd_addr_o), .count_o(count_o), .overflow_o(overflow_o)
    );

    int checks = 0, failures = 0;
    // model: run/c give position within the current frame in clk cycles since slot-0 start
    bit run, e_wd, e_wr, ovf;
    int c, e_waddr, widx, e_gnt, e_raddr, last_g;
    int q[$];

    task automatic check(string tag, int obs, int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int slot_bit(int cc);
        return (cc / (2 * CD)) % SL;
    endfunction

    function automatic bit shift_at(int cc);
        return (cc % (2 * CD)) == CD && slot_bit(cc) >= FIRST && slot_bit(cc) <= LAST;
    endfunction

    function automatic bit write_at_next_edge();
        return run && shift_at(c) && slot_bit(c) == LAST && c / (2 * CD * SL) == 1;
    endfunction

    task automatic model_edge();
        bit wd, right;
        int g;
        wd = run && shift_at(c) && slot_bit(c) == LAST;
        right = c / (2 * CD * SL) == 1;
        g = 0;
        if (reset) begin
            run = 0; c = 0; e_wd = 0; e_wr = 0; e_waddr = 0; widx = 0;
            e_gnt = 0; e_raddr = 0; last_g = 1; ovf = 0; q.delete();
            return;
        end
        e_wd = wd;
        e_wr = wd && right;
        if (!run) begin
            if (enable) begin run = 1; c = 0; end
        end else if (c == F - 1) begin
            c = 0;
            run = enable;
        end else c++;
        if (q.size() > 0 && rd_req_i != 2'b00)
            g = (rd_req_i == 2'b11) ? (last_g == 0 ? 2 : 1) : int'(rd_req_i);
        e_gnt = g;
        if (g != 0) begin
            e_raddr = q.pop_front();
            last_g = (g == 1) ? 0 : 1;
        end
        if (e_wr) begin
            if (q.size() == DEPTH) begin
                void'(q.pop_front());
                ovf = 1;
            end
            q.push_back(widx);
            e_waddr = widx;
            widx = (widx + 1) % DEPTH;
        end
    endtask

    task automatic compare();
        int ws;
        ws = run ? c / (2 * CD * SL) : 0;
        check("sck", int'(sck_o), run ? (c / CD) % 2 : 0);
        check("ws", int'(ws_o), ws);
        check("shift_en", int'(shift_en_o), int'(run && shift_at(c)));
        check("shift_ch", int'(shift_ch_o), ws);
        check("word_done", int'(word_done_o), int'(e_wd));
        check("wr_en", int'(wr_en_o), int'(e_wr));
        check("wr_addr", int'(wr_addr_o), e_waddr);
        check("rd_gnt", int'(rd_gnt_o), e_gnt);
        check("rd_addr", int'(rd_addr_o), e_raddr);
        check("count", int'(count_o), q.size());
        check("overflow", int'(overflow_o), int'(ovf));
    endtask

    task automatic cycle(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            compare();
        end
    endtask

    initial begin
        cycle(3);
        reset = 1'b0;
        enable = 1'b1;
        cycle(1);
        for (int i = 0; i < 12 * F && q.size() < DEPTH; i++) cycle(1);
        for (int i = 0; i < 2 * F && !write_at_next_edge(); i++) cycle(1);
        rd_req_i = 2'b01;
        cycle(1);
        rd_req_i = 2'b00;
        cycle(1);
        check("full_wr_pop_count", int'(count_o), DEPTH);
        check("full_wr_pop_ovf", int'(overflow_o), 0);
        cycle(2 * F);
        check("ovf_set", int'(overflow_o), 1);
        enable = 1'b0;
        cycle(2 * F);
        rd_req_i = 2'b11;
        cycle(14);
        rd_req_i = 2'b00;
        check("drained", int'(count_o), 0);
        enable = 1'b1;
        cycle(20);
        enable = 1'b0;
        cycle(F + 20);
        check("idle_sck", int'(sck_o), 0);
        check("idle_ws", int'(ws_o), 0);
        enable = 1'b1;
        cycle(30);
        reset = 1'b1;
        cycle(1);
        reset = 1'b0;
        cycle(5);
        for (int i = 0; i < 3000; i++) begin
            rd_req_i = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            reset = ($urandom_range(0, 1999) == 0);
            cycle(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2s_frame_scheduler.md
Name: i2s_frame_scheduler

Overview:
- Master-mode I2S timing generator and sample-buffer sequencer for the audio capture path.
- Drives bit clock and word select, and tells the serial-to-parallel receiver when to sample and which channel.
- Schedules one buffer write per stereo frame and shares the buffer read port between two consumers with round-robin arbitration.

Parameters:
- SAMPLE_BITS, 8: data bits per channel word.
- SLOT_BITS, 16: bit-clock periods per channel slot. Must satisfy SLOT_BITS >= SAMPLE_BITS+1.
- CLK_DIV, 2: clk cycles per half bit-clock period. Must be >= 1.
- DEPTH, 10: frame entries in the sample buffer. Must be >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  run request
- sck_o  out  1  I2S bit clock
- ws_o  out  1  word select (0=left, 1=right)
- shift_en_o  out  1  one-clk pulse: receiver samples data_in
- shift_ch_o  out  1  channel for the current shift (equals ws_o during the slot)
- word_done_o  out  1  one-clk pulse after the last bit of a word
- wr_en_o  out  1  one-clk buffer write pulse, once per frame
- wr_addr_o  out  AW=$clog2(DEPTH)  write entry index
- rd_req_i  in  2  read requests from consumers 0 and 1
- rd_gnt_o  out  2  one-hot grant, registered
- rd_addr_o  out  AW  entry being read; valid while rd_gnt_o != 0
- count_o  out  $clog2(DEPTH+1)  occupied entries
- overflow_o  out  1  sticky; set when a full buffer is overwritten

Behaviour:
- Clock and reset:
  - Reset is synchronous, active-high; clock is clk.
  - Reset values: every output 0. Pointers, counters and arbiter priority also reset. Priority resets to consumer 0.
  - Reset asserted mid-frame aborts the frame; no partial write occurs.
- Divider and bit clock:
  - div_cnt counts 0..CLK_DIV-1 while not IDLE; tick when div_cnt==CLK_DIV-1.
  - sck_o toggles on each tick. Bit period = 2*CLK_DIV clk.
  - "Rise" = the tick that drives sck_o 0->1; "fall" = the tick that drives it 1->0.
- State machine (encoding in package): IDLE, SYNC, DATA, PAD.
  - IDLE: sck_o=0, ws_o=0, bit_cnt=0. When enable=1, go to SYNC next clk; the divider starts there.
  - bit_cnt (0..SLOT_BITS-1) advances on each fall.
  - SYNC covers bit 0 of a slot (the I2S one-bit delay). No shift. Go to DATA at its fall.
  - DATA covers bits 1..SAMPLE_BITS. shift_en_o pulses for one clk coincident with each rise; shift_ch_o=ws_o.
  - word_done_o pulses on the clk after the SAMPLE_BITS-th shift, then enter PAD.
  - If SLOT_BITS==SAMPLE_BITS+1, PAD is zero length.
  - ws_o toggles at the fall ending bit SLOT_BITS-1; bit_cnt wraps to 0 and the state returns to SYNC.
- enable deassertion:
  - The current frame always completes through the end of the right slot.
  - Then go to IDLE, with sck_o and ws_o returning to 0.
  - If enable is reasserted before the frame end, there is no interruption.
- Write scheduling:
  - wr_en_o pulses on the same clk as the right-channel word_done_o. wr_addr_o=wr_ptr.
  - wr_ptr then increments, wrapping DEPTH-1 -> 0.
  - Full (count==DEPTH) and write with no pop: rd_ptr advances (oldest entry dropped), count stays DEPTH, overflow_o is set.
  - overflow_o clears only on reset.
- Read arbitration:
  - Each clk, if count_o>0 (before update) and rd_req_i!=0, grant exactly one requester.
  - Round-robin: the requester not granted most recently has priority; if only one requests, it wins.
  - rd_gnt_o and rd_addr_o=rd_ptr are registered and appear the clk after the request is sampled.
  - Each grant pops one entry: rd_ptr++ with wrap, count--.
  - Empty buffer: no grant, regardless of requests.
- Simultaneous events:
  - Write + pop in the same clk: count unchanged, no overflow, even when full.
  - Write into an empty buffer: readable on the following clk.

Optional Feature:
- Macro: I2S_LEFT_JUSTIFIED_EN.
- Defined: left-justified format. SYNC is removed; DATA covers bits 0..SAMPLE_BITS-1 of the slot and the first shift is at the first rise after the ws_o change. Requires SLOT_BITS >= SAMPLE_BITS.
- Undefined: standard I2S with the one-bit delay, as described above.

Decomposition:
- Package i2s_pkg: state enum (IDLE/SYNC/DATA/PAD), channel constants LEFT=0/RIGHT=1, default parameter constants.
- Sub-module rr_arbiter2: 2-requester round-robin with a registered one-hot grant and a priority flag. It is instantiated once.

Test Plan:
- Reset then enable=1 (CLK_DIV=2, SAMPLE_BITS=8, SLOT_BITS=16) -> sck_o period 4 clk. First shift_en_o at the rise of bit 1. 8 shifts with shift_ch_o=0. ws_o rises 64 clk after SYNC entry. wr_en_o at frame end with wr_addr_o=0; frame = 128 clk.
- Run 12 frames with no reads, DEPTH=10 -> count_o saturates at 10; overflow_o set at the 11th write; wr_addr_o sequence 0..9,0,1.
- Both rd_req_i=2'b11 with count=4 -> grants 01,10,01,10 on consecutive clks, rd_addr_o 0,1,2,3; count reaches 0, then no grant.
- Full buffer, write and grant in the same clk -> count stays 10, overflow_o stays 0.
- enable dropped mid-left-slot -> frame completes, one write occurs, then IDLE with sck_o=0 and ws_o=0. Reset asserted mid-DATA -> all outputs 0 next clk, no wr_en_o.
- I2S_LEFT_JUSTIFIED_EN defined -> first shift at the rise of bit 0 of each slot; still 8 shifts per slot.
